// File: rtl/matmul_seq_pkg.sv
// Shared types and sizes for the matmul host-side sequencer.
package matmul_seq_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        SEND = 2'd3
    } seq_state_t;

    localparam int N_OPERANDS = 8;
    localparam int N_RESULTS  = 4;
    localparam int DATA_W     = 8;

endpackage

// File: rtl/matmul_host_seq.sv
// Host sequencer: streams 8 operand bytes into the 2x2 matmul controller, then reads
// back and streams the 4 result bytes. MATMUL_SEQ_TIMEOUT_EN adds a WAIT-state timeout.
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accepting operand bytes, one load_en pulse per transfer
// WAIT  | all operands loaded, waiting for controller done
// READ  | output_en pulse for result rcnt, capture out_data
// SEND  | presenting captured result byte until consumer accepts
module matmul_host_seq
    import matmul_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              load_en,
    output logic              load_sel_ab,
    output logic [1:0]        load_index,
    output logic [DATA_W-1:0] in_data,
    output logic              output_en,
    output logic [1:0]        output_sel,
    input  logic [DATA_W-1:0] out_data,
    input  logic              done,
    output logic              busy,
    output logic              err
);

    localparam logic [2:0] LAST_OP  = 3'(N_OPERANDS - 1);
    localparam logic [1:0] LAST_RES = 2'(N_RESULTS - 1);

    seq_state_t        r_state, w_state;
    logic [2:0]        r_cnt, w_cnt;
    logic [1:0]        r_rcnt, w_rcnt;
    logic              r_s_ready, w_s_ready;
    logic              r_m_valid, w_m_valid;
    logic [DATA_W-1:0] r_m_data, w_m_data;
    logic              r_m_last, w_m_last;
    logic              r_load_en, w_load_en;
    logic              r_load_sel_ab, w_load_sel_ab;
    logic [1:0]        r_load_index, w_load_index;
    logic [DATA_W-1:0] r_in_data, w_in_data;
    logic              r_output_en, w_output_en;
    logic [1:0]        r_output_sel, w_output_sel;
    logic              r_busy, w_busy;
    logic              w_s_xfer, w_m_xfer;

`ifdef MATMUL_SEQ_TIMEOUT_EN
    localparam int WT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WT_W-1:0] r_wcnt, w_wcnt;
    logic            r_err, w_err;
`endif

    assign w_s_xfer = s_valid & r_s_ready;
    assign w_m_xfer = r_m_valid & m_ready;

    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_rcnt        = r_rcnt;
        w_s_ready     = r_s_ready;
        w_m_valid     = r_m_valid;
        w_m_data      = r_m_data;
        w_m_last      = r_m_last;
        w_load_en     = 1'b0;
        w_load_sel_ab = r_load_sel_ab;
        w_load_index  = r_load_index;
        w_in_data     = r_in_data;
        w_output_en   = 1'b0;
        w_output_sel  = r_output_sel;
`ifdef MATMUL_SEQ_TIMEOUT_EN
        w_wcnt        = r_wcnt;
        w_err         = r_err;
`endif
        unique case (r_state)
            LOAD: begin
                if (w_s_xfer) begin
                    w_load_en     = 1'b1;
                    w_load_sel_ab = r_cnt[2];
                    w_load_index  = r_cnt[1:0];
                    w_in_data     = s_data;
                    if (r_cnt == LAST_OP) begin
                        // cnt parks at its terminal value until the next LOAD entry
                        w_state   = WAIT;
                        w_s_ready = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
                        w_wcnt    = WT_W'(TIMEOUT_CYC - 1);
`endif
                    end else begin
                        w_cnt = r_cnt + 3'd1;
                    end
                end
            end
            WAIT: begin
                if (done) begin
                    w_state      = READ;
                    w_rcnt       = 2'd0;
                    w_output_en  = 1'b1;
                    w_output_sel = 2'd0;
                end
`ifdef MATMUL_SEQ_TIMEOUT_EN
                else if (r_wcnt == '0) begin
                    w_err     = 1'b1;
                    w_state   = LOAD;
                    w_cnt     = 3'd0;
                    w_s_ready = 1'b1;
                end else begin
                    w_wcnt = r_wcnt - 1'b1;
                end
`endif
            end
            READ: begin
                w_m_data  = out_data;
                w_m_last  = (r_rcnt == LAST_RES);
                w_m_valid = 1'b1;
                w_state   = SEND;
            end
            SEND: begin
                if (w_m_xfer) begin
                    w_m_valid = 1'b0;
                    w_m_last  = 1'b0;
                    if (r_rcnt == LAST_RES) begin
                        w_state   = LOAD;
                        w_cnt     = 3'd0;
                        w_s_ready = 1'b1;
                    end else begin
                        // later reads are not gated by done
                        w_rcnt       = r_rcnt + 2'd1;
                        w_state      = READ;
                        w_output_en  = 1'b1;
                        w_output_sel = r_rcnt + 2'd1;
                    end
                end
            end
            default: w_state = LOAD;
        endcase
        w_busy = (w_state != LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= LOAD;
            r_cnt         <= 3'd0;
            r_rcnt        <= 2'd0;
            r_s_ready     <= 1'b1;
            r_m_valid     <= 1'b0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_load_en     <= 1'b0;
            r_load_sel_ab <= 1'b0;
            r_load_index  <= 2'd0;
            r_in_data     <= '0;
            r_output_en   <= 1'b0;
            r_output_sel  <= 2'd0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_rcnt        <= w_rcnt;
            r_s_ready     <= w_s_ready;
            r_m_valid     <= w_m_valid;
            r_m_data      <= w_m_data;
            r_m_last      <= w_m_last;
            r_load_en     <= w_load_en;
            r_load_sel_ab <= w_load_sel_ab;
            r_load_index  <= w_load_index;
            r_in_data     <= w_in_data;
            r_output_en   <= w_output_en;
            r_output_sel  <= w_output_sel;
            r_busy        <= w_busy;
        end
    end

`ifdef MATMUL_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wcnt <= w_wcnt;
            r_err  <= w_err;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign s_ready     = r_s_ready;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_last      = r_m_last;
    assign load_en     = r_load_en;
    assign load_sel_ab = r_load_sel_ab;
    assign load_index  = r_load_index;
    assign in_data     = r_in_data;
    assign output_en   = r_output_en;
    assign output_sel  = r_output_sel;
    assign busy        = r_busy;

endmodule

// File: tb/tb_matmul_host_seq.sv
// Directed bench for matmul_host_seq with a behavioural 2x2 controller read port.
// Honours MATMUL_SEQ_TIMEOUT_EN when checking the WAIT timeout.
module tb_matmul_host_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_ready;
    logic       load_en;
    logic       load_sel_ab;
    logic [1:0] load_index;
    logic [7:0] in_data;
    logic       output_en;
    logic [1:0] output_sel;
    logic [7:0] out_data;
    logic       done;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] load_q [$];
    logic [1:0]  oe_q [$];
    logic [8:0]  res_q [$];
    int          n_acc = 0;
    int          n_b2b = 0;
    logic        prev_oe = 1'b0;

    logic [7:0] c_tbl [4] = '{8'd19, 8'd22, 8'd43, 8'd50};

    always #5 clk = ~clk;

    assign out_data = output_en ? c_tbl[output_sel] : 8'h00;

    matmul_host_seq dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .load_en(load_en), .load_sel_ab(load_sel_ab), .load_index(load_index),
        .in_data(in_data), .output_en(output_en), .output_sel(output_sel),
        .out_data(out_data), .done(done), .busy(busy), .err(err)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (load_en) load_q.push_back({load_sel_ab, load_index, in_data});
            if (output_en) begin
                oe_q.push_back(output_sel);
                if (prev_oe) n_b2b++;
            end
            prev_oe = output_en;
            if (m_valid && m_ready) res_q.push_back({m_last, m_data});
            if (s_valid && s_ready) n_acc++;
        end else begin
            prev_oe = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load8(input logic [7:0] base);
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'(base + i);
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        int k;
        int c;
        int pat [16] = '{1,0,1,1,0,1,0,1,1,1,0,1,1,1,0,1};
        logic [10:0] e;

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0; done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_load_en", load_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_output_en", output_en, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_m_data", m_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back load of 01..08
        s_valid = 1'b1;
        s_data  = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_load_en", load_en, 1);
            check("t1_sel", load_sel_ab, (i >> 2) & 1);
            check("t1_idx", load_index, i & 3);
            check("t1_data", in_data, i + 1);
            s_data = 8'(i + 2);
        end
        check("t1_s_ready_low", s_ready, 0);
        check("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        check("t1_no_9th_acc", n_acc, 8);
        check("t1_no_9th_pulse", load_q.size(), 8);
        check("t1_load_en_idle", load_en, 0);
        s_valid = 1'b0;

        // result readback with done dropping after the first read
        m_ready = 1'b1;
        done    = 1'b1;
        c = 0;
        while (!output_en && c < 10) begin @(negedge clk); c++; end
        check("t3_first_oe", output_en, 1);
        done = 1'b0;
        c = 0;
        while (res_q.size() < 4 && c < 40) begin @(negedge clk); c++; end
        check("t3_res_count", res_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_res_data", res_q[i][7:0], c_tbl[i]);
            check("t3_res_last", res_q[i][8], (i == 3) ? 1 : 0);
            check("t3_oe_sel", oe_q[i], i);
        end
        check("t3_oe_count", oe_q.size(), 4);
        check("t3_s_ready_back", s_ready, 1);
        check("t3_busy_idle", busy, 0);
        check("t3_m_valid_idle", m_valid, 0);

        // gapped load
        load_q.delete();
        n_acc = 0;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            s_valid = pat[i][0];
            s_data  = 8'(8'h11 + k);
            if (pat[i] != 0) k++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("t2_acc", n_acc, 8);
        check("t2_pulses", load_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            e = {1'(i >> 2), 2'(i), 8'(8'h11 + i)};
            check("t2_order", load_q[i], e);
        end

        // consumer stall on the second result
        oe_q.delete();
        m_ready = 1'b0;
        done    = 1'b1;
        c = 0;
        while (!m_valid && c < 10) begin @(negedge clk); c++; end
        check("t4_r0_valid", m_valid, 1);
        check("t4_r0_data", m_data, 19);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        done    = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_valid", m_valid, 1);
            check("t4_hold_data", m_data, 22);
            check("t4_hold_no_oe", output_en, 0);
            @(negedge clk);
        end
        check("t4_oe_count", oe_q.size(), 2);

        // async reset while SEND holds result 2
        rst_n = 1'b0;
        #1;
        check("t5_m_valid", m_valid, 0);
        check("t5_output_en", output_en, 0);
        check("t5_s_ready", s_ready, 1);
        check("t5_busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_restart_oe", oe_q.size(), 2);
        check("t5_m_valid_after", m_valid, 0);
        check("t5_s_ready_after", s_ready, 1);

        // done never arrives
        load8(8'h31);
        check("t6_in_wait", s_ready, 0);
`ifdef MATMUL_SEQ_TIMEOUT_EN
        c = 0;
        while (!err && c < 200) begin @(negedge clk); c++; end
        check("t6_err", err, 1);
        check("t6_err_cycle", c, 64);
        check("t6_s_ready", s_ready, 1);
        check("t6_no_read", oe_q.size(), 2);
`else
        repeat (80) @(negedge clk);
        check("t6_s_ready_stuck", s_ready, 0);
        check("t6_err_zero", err, 0);
        check("t6_busy", busy, 1);
        check("t6_no_read", oe_q.size(), 2);
`endif
        check("t6_no_b2b_oe", n_b2b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
